// File: rtl/uP_pkg.sv
// Shared definitions for the program loader: loader states, frame field sizes
// and the program-memory address width.
package uP_pkg;

  localparam int ADDR_W    = 12;
  localparam int ADDR_NIBS = 3;
  localparam int LEN_NIBS  = 3;
  localparam int DATA_NIBS = 2;

  localparam logic [ADDR_W-1:0] ADDR_ONE = 12'd1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    LEN     = 3'd2,
    DATA_HI = 3'd3,
    DATA_LO = 3'd4,
    WRITE   = 3'd5,
    FIN     = 3'd6
  } state_t;

endpackage

// File: rtl/nibble_shift12.sv
// 12-bit shift-in register, most significant nibble first. complete flags the
// shift that delivers the final nibble of the field.
module nibble_shift12
  import uP_pkg::*;
#(
  parameter int NIBS = ADDR_NIBS
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              shift_en,
  input  logic [3:0]        nib,
  output logic [ADDR_W-1:0] value,
  output logic              complete
);

  localparam logic [1:0] LAST = 2'(NIBS - 1);

  logic [1:0] cnt;

  assign complete = shift_en && (cnt == LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      value <= '0;
      cnt   <= '0;
    end else if (clear) begin
      value <= '0;
      cnt   <= '0;
    end else if (shift_en) begin
      value <= {value[ADDR_W-5:0], nib};
      cnt   <= complete ? 2'd0 : cnt + 2'd1;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Nibble-stream program loader: parses address/count/data frames and writes
// program bytes while holding the processor in reset.
//
// state   | meaning
// IDLE    | waiting for start, processor released
// ADDR    | shifting in 3 start-address nibbles
// LEN     | shifting in 3 byte-count nibbles
// DATA_HI | waiting for high nibble of next byte
// DATA_LO | waiting for low nibble of next byte
// WRITE   | one-cycle memory write of the assembled byte
// FIN     | one-cycle done pulse
module prog_loader
  import uP_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [3:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [4*DATA_NIBS-1:0] mem_wdata,
  output logic                   cpu_hold,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  state_t            state, state_d;
  logic              hs, start_ok, stop;
  logic              addr_sh, len_sh, addr_cmp, len_cmp;
  logic              len_zero, fresh;
  logic [ADDR_W-1:0] addr_value, len_value, cur_addr, remain, rem_cur;
  logic [3:0]        hi_q, lo_q;

  assign hs       = in_valid && in_ready;
  assign start_ok = (state == IDLE) && start;
  assign stop     = abort && (state != IDLE);
  assign addr_sh  = (state == ADDR) && hs && !abort;
  assign len_sh   = (state == LEN) && hs && !abort;
  assign len_zero = (len_value[7:0] == 8'h00) && (in_data == 4'h0);
  // The count register is only complete from DATA_HI on, so the first WRITE
  // takes the remaining count from it directly.
  assign rem_cur  = fresh ? len_value : remain;

  assign mem_addr  = cur_addr;
  assign mem_wdata = {hi_q, lo_q};

  nibble_shift12 #(.NIBS(ADDR_NIBS)) u_addr (
    .clock    (clock),
    .reset    (reset),
    .clear    (start_ok),
    .shift_en (addr_sh),
    .nib      (in_data),
    .value    (addr_value),
    .complete (addr_cmp)
  );

  nibble_shift12 #(.NIBS(LEN_NIBS)) u_len (
    .clock    (clock),
    .reset    (reset),
    .clear    (start_ok),
    .shift_en (len_sh),
    .nib      (in_data),
    .value    (len_value),
    .complete (len_cmp)
  );

  always_comb begin
    state_d  = state;
    in_ready = 1'b0;
    mem_we   = 1'b0;
    done     = 1'b0;
    busy     = (state != IDLE);
    cpu_hold = (state != IDLE);
    case (state)
      IDLE:    if (start) state_d = ADDR;
      ADDR: begin
        in_ready = 1'b1;
        if (addr_cmp) state_d = LEN;
      end
      LEN: begin
        in_ready = 1'b1;
        if (len_cmp) state_d = len_zero ? FIN : DATA_HI;
      end
      DATA_HI: begin
        in_ready = 1'b1;
        if (hs) state_d = DATA_LO;
      end
      DATA_LO: begin
        in_ready = 1'b1;
        if (hs) state_d = WRITE;
      end
      WRITE: begin
        mem_we  = 1'b1;
        state_d = (rem_cur == ADDR_ONE) ? FIN : DATA_HI;
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (stop) state_d = IDLE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err      <= 1'b0;
      fresh    <= 1'b0;
      cur_addr <= '0;
      remain   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      if (start_ok) begin
        err   <= 1'b0;
        fresh <= 1'b0;
      end else if (stop) begin
        err <= 1'b1;
      end
      if (!abort) begin
        if (len_cmp) begin
          cur_addr <= addr_value;
          fresh    <= 1'b1;
        end
        if (state == DATA_HI && hs) hi_q <= in_data;
        if (state == DATA_LO && hs) lo_q <= in_data;
        if (state == WRITE) begin
          cur_addr <= cur_addr + ADDR_ONE;
          remain   <= rem_cur - ADDR_ONE;
          fresh    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: per-cycle vector table plus hand-written
// reset-in-frame sequence.
module tb_prog_loader;

  logic        clock, reset, start, abort, in_valid;
  logic [3:0]  in_data;
  logic        in_ready, mem_we, cpu_hold, busy, done, err;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;

  int n_tests = 0;
  int n_fail  = 0;

  prog_loader dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic        st, ab, v;
    logic [3:0]  d;
    logic        rdy, we;
    logic [11:0] a;
    logic [7:0]  w;
    logic        bsy, dn, er;
  } vec_t;

  vec_t vecs[$];

  task automatic row(input string n, input logic st, input logic ab, input logic v,
                     input logic [3:0] d, input logic rdy, input logic we,
                     input logic [11:0] a, input logic [7:0] w, input logic bsy,
                     input logic dn, input logic er);
    vec_t x;
    x.name = n; x.st = st; x.ab = ab; x.v = v; x.d = d;
    x.rdy = rdy; x.we = we; x.a = a; x.w = w; x.bsy = bsy; x.dn = dn; x.er = er;
    vecs.push_back(x);
  endtask

  task automatic check_vec(input int i);
    vec_t x;
    logic ok;
    x = vecs[i];
    ok = (in_ready === x.rdy) && (mem_we === x.we) && (busy === x.bsy) &&
         (cpu_hold === x.bsy) && (done === x.dn) && (err === x.er);
    if (x.we) ok = ok && (mem_addr === x.a) && (mem_wdata === x.w);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s[%0d]: got rdy=%b we=%b addr=%h data=%h busy=%b hold=%b done=%b err=%b, expected rdy=%b we=%b addr=%h data=%h busy=%b hold=%b done=%b err=%b",
               x.name, i, in_ready, mem_we, mem_addr, mem_wdata, busy, cpu_hold, done, err,
               x.rdy, x.we, x.a, x.w, x.bsy, x.bsy, x.dn, x.er);
    end
  endtask

  task automatic run(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      @(negedge clock);
      start = vecs[i].st; abort = vecs[i].ab; in_valid = vecs[i].v; in_data = vecs[i].d;
      #1 check_vec(i);
    end
  endtask

  task automatic drv(input logic st, input logic v, input logic [3:0] d);
    @(negedge clock);
    start = st; abort = 1'b0; in_valid = v; in_data = d;
  endtask

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", n, got, exp);
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = 4'h0;

    // frame A: addr 0x010, count 2, bytes A5 3C
    row("a", 1,0,0,4'h0, 0,0,12'h000,8'h00, 0,0,0);
    row("a", 0,0,1,4'h0, 1,0,12'h000,8'h00, 1,0,0);
    row("a", 0,0,1,4'h1, 1,0,12'h000,8'h00, 1,0,0);
    row("a", 0,0,1,4'h0, 1,0,12'h000,8'h00, 1,0,0);
    row("a", 0,0,1,4'h0, 1,0,12'h000,8'h00, 1,0,0);
    row("a", 0,0,1,4'h0, 1,0,12'h000,8'h00, 1,0,0);
    row("a", 0,0,1,4'h2, 1,0,12'h000,8'h00, 1,0,0);
    row("a", 0,0,1,4'hA, 1,0,12'h000,8'h00, 1,0,0);
    row("a", 0,0,1,4'h5, 1,0,12'h000,8'h00, 1,0,0);
    row("a", 0,0,1,4'hF, 0,1,12'h010,8'hA5, 1,0,0);
    row("a", 0,0,1,4'h3, 1,0,12'h000,8'h00, 1,0,0);
    row("a", 0,0,1,4'hC, 1,0,12'h000,8'h00, 1,0,0);
    row("a", 0,0,0,4'h0, 0,1,12'h011,8'h3C, 1,0,0);
    row("a", 0,0,0,4'h0, 0,0,12'h000,8'h00, 1,1,0);
    row("a", 0,0,0,4'h0, 0,0,12'h000,8'h00, 0,0,0);
    // frame B: address wrap 0xFFF -> 0x000
    row("wrap", 1,0,0,4'h0, 0,0,12'h000,8'h00, 0,0,0);
    row("wrap", 0,0,1,4'hF, 1,0,12'h000,8'h00, 1,0,0);
    row("wrap", 0,0,1,4'hF, 1,0,12'h000,8'h00, 1,0,0);
    row("wrap", 0,0,1,4'hF, 1,0,12'h000,8'h00, 1,0,0);
    row("wrap", 0,0,1,4'h0, 1,0,12'h000,8'h00, 1,0,0);
    row("wrap", 0,0,1,4'h0, 1,0,12'h000,8'h00, 1,0,0);
    row("wrap", 0,0,1,4'h2, 1,0,12'h000,8'h00, 1,0,0);
    row("wrap", 0,0,1,4'h1, 1,0,12'h000,8'h00, 1,0,0);
    row("wrap", 0,0,1,4'h2, 1,0,12'h000,8'h00, 1,0,0);
    row("wrap", 0,0,0,4'h0, 0,1,12'hFFF,8'h12, 1,0,0);
    row("wrap", 0,0,1,4'h3, 1,0,12'h000,8'h00, 1,0,0);
    row("wrap", 0,0,1,4'h4, 1,0,12'h000,8'h00, 1,0,0);
    row("wrap", 0,0,0,4'h0, 0,1,12'h000,8'h34, 1,0,0);
    row("wrap", 0,0,0,4'h0, 0,0,12'h000,8'h00, 1,1,0);
    row("wrap", 0,0,0,4'h0, 0,0,12'h000,8'h00, 0,0,0);
    // frame C: zero count
    row("zero", 1,0,0,4'h0, 0,0,12'h000,8'h00, 0,0,0);
    row("zero", 0,0,1,4'h0, 1,0,12'h000,8'h00, 1,0,0);
    row("zero", 0,0,1,4'h0, 1,0,12'h000,8'h00, 1,0,0);
    row("zero", 0,0,1,4'h5, 1,0,12'h000,8'h00, 1,0,0);
    row("zero", 0,0,1,4'h0, 1,0,12'h000,8'h00, 1,0,0);
    row("zero", 0,0,1,4'h0, 1,0,12'h000,8'h00, 1,0,0);
    row("zero", 0,0,1,4'h0, 1,0,12'h000,8'h00, 1,0,0);
    row("zero", 0,0,0,4'h0, 0,0,12'h000,8'h00, 1,1,0);
    row("zero", 0,0,0,4'h0, 0,0,12'h000,8'h00, 0,0,0);
    // frame A with in_valid toggling every cycle
    row("tog", 1,0,0,4'h0, 0,0,12'h000,8'h00, 0,0,0);
    row("tog", 0,0,1,4'h0, 1,0,12'h000,8'h00, 1,0,0);
    row("tog", 0,0,0,4'hF, 1,0,12'h000,8'h00, 1,0,0);
    row("tog", 0,0,1,4'h1, 1,0,12'h000,8'h00, 1,0,0);
    row("tog", 0,0,0,4'hF, 1,0,12'h000,8'h00, 1,0,0);
    row("tog", 0,0,1,4'h0, 1,0,12'h000,8'h00, 1,0,0);
    row("tog", 0,0,0,4'hF, 1,0,12'h000,8'h00, 1,0,0);
    row("tog", 0,0,1,4'h0, 1,0,12'h000,8'h00, 1,0,0);
    row("tog", 0,0,0,4'hF, 1,0,12'h000,8'h00, 1,0,0);
    row("tog", 0,0,1,4'h0, 1,0,12'h000,8'h00, 1,0,0);
    row("tog", 0,0,0,4'hF, 1,0,12'h000,8'h00, 1,0,0);
    row("tog", 0,0,1,4'h2, 1,0,12'h000,8'h00, 1,0,0);
    row("tog", 0,0,0,4'hF, 1,0,12'h000,8'h00, 1,0,0);
    row("tog", 0,0,1,4'hA, 1,0,12'h000,8'h00, 1,0,0);
    row("tog", 0,0,0,4'hF, 1,0,12'h000,8'h00, 1,0,0);
    row("tog", 0,0,1,4'h5, 1,0,12'h000,8'h00, 1,0,0);
    row("tog", 0,0,0,4'hF, 0,1,12'h010,8'hA5, 1,0,0);
    row("tog", 0,0,1,4'h3, 1,0,12'h000,8'h00, 1,0,0);
    row("tog", 0,0,0,4'hF, 1,0,12'h000,8'h00, 1,0,0);
    row("tog", 0,0,1,4'hC, 1,0,12'h000,8'h00, 1,0,0);
    row("tog", 0,0,0,4'hF, 0,1,12'h011,8'h3C, 1,0,0);
    row("tog", 0,0,1,4'h0, 0,0,12'h000,8'h00, 1,1,0);
    row("tog", 0,0,0,4'h0, 0,0,12'h000,8'h00, 0,0,0);
    // start while busy ignored, abort after first data nibble, abort in WRITE
    row("abort", 1,0,0,4'h0, 0,0,12'h000,8'h00, 0,0,0);
    row("abort", 1,0,1,4'h0, 1,0,12'h000,8'h00, 1,0,0);
    row("abort", 0,0,1,4'h2, 1,0,12'h000,8'h00, 1,0,0);
    row("abort", 0,0,1,4'h0, 1,0,12'h000,8'h00, 1,0,0);
    row("abort", 0,0,1,4'h0, 1,0,12'h000,8'h00, 1,0,0);
    row("abort", 0,0,1,4'h0, 1,0,12'h000,8'h00, 1,0,0);
    row("abort", 0,0,1,4'h1, 1,0,12'h000,8'h00, 1,0,0);
    row("abort", 0,0,1,4'h7, 1,0,12'h000,8'h00, 1,0,0);
    row("abort", 0,1,1,4'h8, 1,0,12'h000,8'h00, 1,0,0);
    row("abort", 0,0,0,4'h0, 0,0,12'h000,8'h00, 0,0,1);
    row("abort", 1,0,0,4'h0, 0,0,12'h000,8'h00, 0,0,1);
    row("abort", 0,0,1,4'h0, 1,0,12'h000,8'h00, 1,0,0);
    row("abort", 0,0,1,4'h3, 1,0,12'h000,8'h00, 1,0,0);
    row("abort", 0,0,1,4'h0, 1,0,12'h000,8'h00, 1,0,0);
    row("abort", 0,0,1,4'h0, 1,0,12'h000,8'h00, 1,0,0);
    row("abort", 0,0,1,4'h0, 1,0,12'h000,8'h00, 1,0,0);
    row("abort", 0,0,1,4'h2, 1,0,12'h000,8'h00, 1,0,0);
    row("abort", 0,0,1,4'h1, 1,0,12'h000,8'h00, 1,0,0);
    row("abort", 0,0,1,4'h1, 1,0,12'h000,8'h00, 1,0,0);
    row("abort", 0,1,0,4'h0, 0,1,12'h030,8'h11, 1,0,0);
    row("abort", 0,0,0,4'h0, 0,0,12'h000,8'h00, 0,0,1);
    row("abort", 0,1,1,4'h5, 0,0,12'h000,8'h00, 0,0,1);
    row("abort", 1,0,0,4'h0, 0,0,12'h000,8'h00, 0,0,1);
    row("abort", 0,1,1,4'h0, 1,0,12'h000,8'h00, 1,0,0);
    row("abort", 0,0,0,4'h0, 0,0,12'h000,8'h00, 0,0,1);

    repeat (2) @(posedge clock);
    #1;
    chk("reset_outputs", {20'h0, in_ready, mem_we, busy, cpu_hold, done, err, 6'h0},
        32'h0);
    chk("reset_addr_data", {12'h0, mem_addr, mem_wdata}, 32'h0);
    @(negedge clock);
    reset = 1'b1;

    run(0, vecs.size() - 1);

    // reset asserted while in DATA_LO
    drv(1, 0, 4'h0);
    drv(0, 1, 4'h0); drv(0, 1, 4'h4); drv(0, 1, 4'h0);
    drv(0, 1, 4'h0); drv(0, 1, 4'h0); drv(0, 1, 4'h2);
    drv(0, 1, 4'h6);
    drv(0, 1, 4'h7);
    #1 chk("pre_reset_in_data_lo", {30'h0, busy, in_ready}, 32'h3);
    #2 reset = 1'b0;
    #1 chk("reset_async_ctrl", {26'h0, in_ready, mem_we, busy, cpu_hold, done, err},
           32'h0);
    chk("reset_async_addr_data", {12'h0, mem_addr, mem_wdata}, 32'h0);
    @(negedge clock);
    chk("reset_held", {30'h0, mem_we, busy}, 32'h0);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drv(0, 1, 4'hF);
      #1 chk("idle_after_reset", {29'h0, in_ready, mem_we, busy}, 32'h0);
    end
    run(0, 14);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have port clock, input, 1 bit: single rising-edge clock.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1 bit: one-cycle load request, honoured only in IDLE.
REQ-004 SHALL have port abort, input, 1 bit: synchronous cancel of a load in progress.
REQ-005 SHALL have port in_data, input, 4 bits: nibble stream payload.
REQ-006 SHALL have port in_valid, input, 1 bit: in_data is valid this cycle.
REQ-007 SHALL have port in_ready, output, 1 bit: nibble accepted when in_valid && in_ready.
REQ-008 SHALL have port mem_we, output, 1 bit: program-memory write strobe, one cycle per byte.
REQ-009 SHALL have port mem_addr, output, 12 bits: program-memory byte address, same width as PC.
REQ-010 SHALL have port mem_wdata, output, 8 bits: program byte (instr in [7:4], oprnd in [3:0]).
REQ-011 SHALL have port cpu_hold, output, 1 bit: held high to keep the processor in reset while loading.
REQ-012 SHALL have port busy, output, 1 bit: state != IDLE.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse on successful completion.
REQ-014 SHALL have port err, output, 1 bit: sticky; set on abort, cleared by the next accepted start.

Function
REQ-015 Frame format SHALL be: 3 address nibbles (MSN first), then 3 count nibbles (MSN first), then 2*count data nibbles (high nibble first per byte).
REQ-016 SHALL use states IDLE, ADDR, LEN, DATA_HI, DATA_LO, WRITE, FIN.
REQ-017 IDLE -> ADDR on start; busy and cpu_hold SHALL rise the cycle after start.
REQ-018 ADDR -> LEN after the 3rd accepted nibble; a nibble counter SHALL track the nibble position.
REQ-019 LEN -> DATA_HI after the 3rd nibble when count != 0; LEN -> FIN when count == 0 (no writes).
REQ-020 DATA_HI SHALL latch the high nibble, then go to DATA_LO; DATA_LO SHALL latch the low nibble, then go to WRITE.
REQ-021 In WRITE (one cycle): mem_we=1, mem_addr=current address, mem_wdata=assembled byte, in_ready=0.
REQ-022 After WRITE the address SHALL increment mod 4096 (0xFFF wraps to 0x000) and remaining count SHALL decrement; -> DATA_HI if remaining != 0, else -> FIN.
REQ-023 Write latency: mem_we SHALL assert exactly one cycle after the low nibble handshake.
REQ-024 in_ready SHALL be 1 in ADDR, LEN, DATA_HI and DATA_LO, and 0 in IDLE, WRITE and FIN.
REQ-025 Stalls (in_valid=0) SHALL hold state indefinitely with no timeout.
REQ-026 FIN (one cycle): done=1; the next state SHALL be IDLE, where cpu_hold, busy and done are 0.
REQ-027 start while busy SHALL be ignored and SHALL NOT set err.
REQ-028 abort in any non-IDLE state SHALL go to IDLE next cycle and set err with no done.
REQ-029 abort SHALL take priority over a simultaneous handshake or write; a WRITE-cycle mem_we still issued that cycle SHALL stand.
REQ-030 mem_we SHALL never assert outside WRITE.

Reset
REQ-031 On reset low, asynchronously: state=IDLE, address/count/nibble registers=0, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=0, busy=0, done=0, err=0.
REQ-032 Reset mid-frame SHALL discard the frame with no further writes; the loader SHALL resume only on a new start.

Structure
REQ-033 State encoding, frame nibble counts (3/3/2) and the address width 12 SHALL be defined in a shared package, uP_pkg.
REQ-034 A single sub-module, nibble_shift12 (12-bit MSN-first shift-in register with load-complete flag), SHALL be used for both the address and count fields.

Verification
REQ-035 start; nibbles 0,1,0 / 0,0,2 / A,5,3,C -> writes (0x010,0xA5), (0x011,0x3C); done one cycle after the second WRITE; cpu_hold high throughout.
REQ-036 address F,F,F, count 0,0,2, data 1,2,3,4 -> writes (0xFFF,0x12), (0x000,0x34).
REQ-037 count 0,0,0 -> no mem_we; done pulse after the 6th nibble.
REQ-038 in_valid toggled 1/0 every cycle -> same writes as REQ-035; mem_we exactly 1 cycle after each low nibble; in_ready=0 in WRITE.
REQ-039 abort after the first data nibble -> IDLE next cycle, err=1, no mem_we, no done; the next start clears err.
REQ-040 reset low during DATA_LO, then high -> all outputs 0; a subsequent full frame loads correctly.
